serial_magnitude_comparator: RTL and testbench

- Parametrised, multi-cycle magnitude comparator for two WIDTH-bit operands.
- Compares DIGIT bits per cycle, MSB digit first, and stops at the first digit that differs.
- Supports unsigned and two's-complement signed modes, selected per operation.
- Start/busy/done handshake; intended for datapaths where area matters more than single-cycle compare latency.

---
 rtl/serial_magnitude_comparator_if.sv | 39 +++
 rtl/serial_magnitude_comparator.sv | 112 +++++++++++
 tb/tb_serial_magnitude_comparator.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_magnitude_comparator_if.sv
// Start/busy/done handshake bundle for the serial magnitude comparator.
// The master issues operands and start; the slave returns status and result flags.
interface serial_magnitude_comparator_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             gt;
    logic             eq;
    logic             lt;

    modport master (
        output start,
        output signed_mode,
        output a,
        output b,
        input  busy,
        input  done,
        input  gt,
        input  eq,
        input  lt
    );

    modport slave (
        input  start,
        input  signed_mode,
        input  a,
        input  b,
        output busy,
        output done,
        output gt,
        output eq,
        output lt
    );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle magnitude comparator: DIGIT bits per cycle, MSB digit first,
// early exit on the first differing digit; signed mode uses offset-binary.
module serial_magnitude_comparator #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    serial_magnitude_comparator_if.slave    cmp
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(N - 1);

    typedef enum logic {
        IDLE,
        COMPARE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             gt_q;
    logic             eq_q;
    logic             lt_q;

    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [DIGIT-1:0] dig_a;
    logic [DIGIT-1:0] dig_b;
    logic             dig_eq;
    logic             dig_gt;

    // Flip the sign bit in signed mode so the rest of the compare is unsigned.
    always_comb begin
        a_in = cmp.a;
        b_in = cmp.b;
        a_in[WIDTH-1] = cmp.a[WIDTH-1] ^ cmp.signed_mode;
        b_in[WIDTH-1] = cmp.b[WIDTH-1] ^ cmp.signed_mode;
    end

    // Compare the current top digit of both shift registers.
    always_comb begin
        dig_a  = a_q[WIDTH-1 -: DIGIT];
        dig_b  = b_q[WIDTH-1 -: DIGIT];
        dig_eq = (dig_a == dig_b);
        dig_gt = (dig_a > dig_b);
    end

    // Control FSM with registered status and result flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cmp.start) begin
                        a_q     <= a_in;
                        b_q     <= b_in;
                        cnt_q   <= CNT_MAX;
                        gt_q    <= 1'b0;
                        eq_q    <= 1'b0;
                        lt_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (!dig_eq) begin
                        gt_q    <= dig_gt;
                        lt_q    <= ~dig_gt;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (cnt_q == '0) begin
                        eq_q    <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        a_q   <= a_q << DIGIT;
                        b_q   <= b_q << DIGIT;
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmp.busy = busy_q;
    assign cmp.done = done_q;
    assign cmp.gt   = gt_q;
    assign cmp.eq   = eq_q;
    assign cmp.lt   = lt_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed bench for the serial magnitude comparator (8/2 and 2/2 builds).
// Results are checked as {gt,eq,lt} against hand-computed values.
module tb_serial_magnitude_comparator;

    logic clk;
    logic rst_n;
    int   nvec;
    int   nerr;

    serial_magnitude_comparator_if #(.WIDTH(8)) bus8();
    serial_magnitude_comparator_if #(.WIDTH(2)) bus2();

    serial_magnitude_comparator #(.WIDTH(8), .DIGIT(2)) u8 (
        .clk   (clk),
        .rst_n (rst_n),
        .cmp   (bus8)
    );

    serial_magnitude_comparator #(.WIDTH(2), .DIGIT(2)) u2 (
        .clk   (clk),
        .rst_n (rst_n),
        .cmp   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] res8();
        return {5'd0, bus8.gt, bus8.eq, bus8.lt};
    endfunction

    function automatic logic [7:0] res2();
        return {5'd0, bus2.gt, bus2.eq, bus2.lt};
    endfunction

    task automatic op8(input string tag, input logic [7:0] a,
                       input logic [7:0] b, input logic sm,
                       input logic [7:0] exp_res, input int exp_lat);
        int lat;
        bus8.a           = a;
        bus8.b           = b;
        bus8.signed_mode = sm;
        bus8.start       = 1'b1;
        tick();
        bus8.start = 1'b0;
        chk({tag, "_busy"}, 8'(bus8.busy), 8'd1);
        chk({tag, "_clr"}, res8(), 8'd0);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (bus8.done !== 1'b1 && lat < 20);
        chk({tag, "_lat"}, 8'(lat), 8'(exp_lat));
        chk({tag, "_res"}, res8(), exp_res);
        chk({tag, "_idle"}, 8'(bus8.busy), 8'd0);
        tick();
        chk({tag, "_pulse"}, 8'(bus8.done), 8'd0);
        chk({tag, "_hold"}, res8(), exp_res);
    endtask

    task automatic op2(input logic [1:0] a, input logic [1:0] b,
                       input logic sm);
        int sa;
        int sb;
        int lat;
        logic [7:0] exp_res;
        sa = (sm && a[1]) ? int'(a) - 4 : int'(a);
        sb = (sm && b[1]) ? int'(b) - 4 : int'(b);
        exp_res = (sa > sb) ? 8'd4 : (sa == sb) ? 8'd2 : 8'd1;
        bus2.a           = a;
        bus2.b           = b;
        bus2.signed_mode = sm;
        bus2.start       = 1'b1;
        tick();
        bus2.start = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (bus2.done !== 1'b1 && lat < 10);
        chk($sformatf("w2_lat_s%0d_%0d_%0d", sm, a, b), 8'(lat), 8'd1);
        chk($sformatf("w2_res_s%0d_%0d_%0d", sm, a, b), res2(), exp_res);
    endtask

    initial begin
        int late_done;
        nvec = 0;
        nerr = 0;
        rst_n = 1'b0;
        bus8.start = 1'b0;
        bus8.signed_mode = 1'b0;
        bus8.a = '0;
        bus8.b = '0;
        bus2.start = 1'b0;
        bus2.signed_mode = 1'b0;
        bus2.a = '0;
        bus2.b = '0;

        #12;
        chk("rst_busy", 8'(bus8.busy), 8'd0);
        chk("rst_done", 8'(bus8.done), 8'd0);
        chk("rst_res", res8(), 8'd0);
        rst_n = 1'b1;
        tick();

        op8("c0_40_u", 8'hC0, 8'h40, 1'b0, 8'd4, 1);
        tick();
        tick();
        chk("c0_40_held", res8(), 8'd4);
        op8("5a_5a_u", 8'h5A, 8'h5A, 1'b0, 8'd2, 4);
        op8("12_13_u", 8'h12, 8'h13, 1'b0, 8'd1, 4);
        op8("80_7f_s", 8'h80, 8'h7F, 1'b1, 8'd1, 1);
        op8("80_7f_u", 8'h80, 8'h7F, 1'b0, 8'd4, 1);
        op8("ff_01_s", 8'hFF, 8'h01, 1'b1, 8'd1, 1);
        op8("fe_ff_s", 8'hFE, 8'hFF, 1'b1, 8'd1, 4);

        bus8.a = 8'h01;
        bus8.b = 8'h00;
        bus8.signed_mode = 1'b0;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        chk("hs_busy0", 8'(bus8.busy), 8'd1);
        tick();
        bus8.a = 8'h00;
        bus8.b = 8'hFF;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        chk("hs_ign_busy", 8'(bus8.busy), 8'd1);
        chk("hs_ign_done", 8'(bus8.done), 8'd0);
        tick();
        chk("hs_e3_done", 8'(bus8.done), 8'd0);
        tick();
        chk("hs_done", 8'(bus8.done), 8'd1);
        chk("hs_res1", res8(), 8'd4);
        bus8.a = 8'hFF;
        bus8.b = 8'hFE;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        chk("b2b_busy", 8'(bus8.busy), 8'd1);
        chk("b2b_done", 8'(bus8.done), 8'd0);
        chk("b2b_clr", res8(), 8'd0);
        begin
            int lat;
            lat = 0;
            do begin
                tick();
                lat++;
            end while (bus8.done !== 1'b1 && lat < 20);
            chk("b2b_lat", 8'(lat), 8'd4);
            chk("b2b_res", res8(), 8'd4);
        end
        tick();

        bus8.a = 8'h5A;
        bus8.b = 8'h5A;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 8'(bus8.busy), 8'd0);
        chk("abort_done", 8'(bus8.done), 8'd0);
        chk("abort_res", res8(), 8'd0);
        tick();
        rst_n = 1'b1;
        late_done = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus8.done === 1'b1 || bus8.busy === 1'b1) late_done++;
            tick();
        end
        chk("abort_no_done", 8'(late_done), 8'd0);
        op8("post_rst", 8'h12, 8'h13, 1'b0, 8'd1, 4);

        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    op2(2'(i), 2'(j), 1'(m));
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
